// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// StoreMD encodings are shared with the main control unit's HI/LO write select.
package mult_div_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam logic [1:0] STORE_DIV  = 2'b01;
    localparam logic [1:0] STORE_MULT = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the ALU control path and mult_div_unit.
// Optional macro MULTDIV_UNSIGNED_EN adds the isUnsigned request bit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             multOp;
    logic             divOp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef MULTDIV_UNSIGNED_EN
    logic             isUnsigned;
`endif
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

`ifdef MULTDIV_UNSIGNED_EN
    modport master (output multOp, divOp, a, b, isUnsigned,
                    input  hi, lo, busy, done, div_zero);
    modport slave  (input  multOp, divOp, a, b, isUnsigned,
                    output hi, lo, busy, done, div_zero);
`else
    modport master (output multOp, divOp, a, b,
                    input  hi, lo, busy, done, div_zero);
    modport slave  (input  multOp, divOp, a, b,
                    output hi, lo, busy, done, div_zero);
`endif

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract, keep or restore.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted   = {rem, quot[WIDTH-1]};
    assign diff      = shifted - {1'b0, divisor};
    // A clear borrow bit means the divisor fit, so that quotient bit is 1.
    assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit.
// Optional macro MULTDIV_UNSIGNED_EN enables multu/divu via isUnsigned.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic             uns_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic             start;
    logic             start_uns;
    logic             start_a_neg;
    logic             start_b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef MULTDIV_UNSIGNED_EN
    assign start_uns = bus.isUnsigned;
`else
    assign start_uns = 1'b0;
`endif

    assign start       = bus.multOp | bus.divOp;
    assign start_a_neg = ~start_uns & bus.a[WIDTH-1];
    assign start_b_neg = ~start_uns & bus.b[WIDTH-1];
    assign a_mag       = start_a_neg ? -bus.a : bus.a;
    assign b_mag       = start_b_neg ? -bus.b : bus.b;

    // Booth datapath is two bits wider than the operand so an unsigned
    // multiplicand plus the running partial product cannot overflow.
    logic [WIDTH+1:0] m_sx;
    logic [WIDTH+1:0] acc_sx;
    logic [WIDTH+1:0] booth_sum;

    assign m_sx   = {{2{a_neg_q}}, opnd_q};
    assign acc_sx = {acc_q[WIDTH], acc_q};

    always_comb begin
        // NOTE: assign a default first so no path leaves booth_sum unassigned (latch).
        booth_sum = acc_sx;
        case ({q_q[0], q_m1_q})
            2'b01:   booth_sum = acc_sx + m_sx;
            2'b10:   booth_sum = acc_sx - m_sx;
            default: ;
        endcase
    end

    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quot_next;

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem       (acc_q[WIDTH-1:0]),
        .quot      (q_q),
        .divisor   (opnd_q),
        .rem_next  (div_rem_next),
        .quot_next (div_quot_next)
    );

    // Booth treats the multiplier as signed; an unsigned multiplier with its
    // top bit set needs one more +M digit at 2^WIDTH, i.e. hi += multiplicand.
    logic [WIDTH-1:0] fix_mult_hi;
    logic [WIDTH-1:0] fix_div_hi;
    logic [WIDTH-1:0] fix_div_lo;

    assign fix_mult_hi = acc_q[WIDTH-1:0] + ((uns_q & b_msb_q) ? opnd_q : '0);
    assign fix_div_lo  = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
    assign fix_div_hi  = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= OP_MULT;
            cnt        <= '0;
            uns_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            q_m1_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below sees the
            // pre-edge register values regardless of statement order.
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= bus.multOp ? OP_MULT : OP_DIV;
                        uns_q   <= start_uns;
                        a_neg_q <= start_a_neg;
                        b_neg_q <= start_b_neg;
                        b_msb_q <= bus.b[WIDTH-1];
                        acc_q   <= '0;
                        q_m1_q  <= 1'b0;
                        cnt     <= CW'(WIDTH - 1);
                        if (bus.multOp) begin
                            opnd_q <= bus.a;
                            q_q    <= bus.b;
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end else if (bus.b == '0) begin
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            opnd_q <= b_mag;
                            q_q    <= a_mag;
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q == OP_MULT) begin
                        acc_q  <= booth_sum[WIDTH+1:1];
                        q_q    <= {booth_sum[0], q_q[WIDTH-1:1]};
                        q_m1_q <= q_q[0];
                    end else begin
                        acc_q <= {1'b0, div_rem_next};
                        q_q   <= div_quot_next;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        hi_q <= fix_mult_hi;
                        lo_q <= q_q;
                    end else if (uns_q) begin
                        hi_q <= acc_q[WIDTH-1:0];
                        lo_q <= q_q;
                    end else begin
                        hi_q <= fix_div_hi;
                        lo_q <= fix_div_lo;
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit; expected results come from
// 64-bit integer arithmetic on the operands, not from the datapath.
module tb_mult_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint n, d, qv, rv;
        n  = longint'($signed(x));
        d  = longint'($signed(y));
        qv = n / d;
        rv = n % d;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input bit do_mult, input bit do_div, input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        bus.multOp = do_mult;
        bus.divOp  = do_div;
        bus.a      = xa;
        bus.b      = xb;
        @(posedge clk);
        #1;
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string tag, input bit do_mult, input bit do_div,
                                 input logic [31:0] xa, input logic [31:0] xb);
        int lat, busy_n;
        logic [63:0] r;
        bit dz;
        dz = 1'b0;
        if (do_mult) begin
            r = ref_mult(xa, xb);
            {exp_hi, exp_lo} = r;
        end else if (xb == 32'h0) begin
            dz = 1'b1;
        end else begin
            r = ref_div(xa, xb);
            {exp_hi, exp_lo} = r;
        end
        issue(do_mult, do_div, xa, xb);
        wait_done(lat, busy_n);
        check({tag, ".latency"}, 64'(lat), dz ? 64'd0 : 64'd33);
        check({tag, ".busy_cycles"}, 64'(busy_n), dz ? 64'd0 : 64'd33);
        check({tag, ".div_zero"}, {63'd0, bus.div_zero}, {63'd0, dz});
        check({tag, ".hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
`ifdef MULTDIV_UNSIGNED_EN
        bus.isUnsigned = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        reset_n = 1'b1;

        run_and_check("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul_7_m3.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_and_check("mul_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("mul_max.const", {bus.hi, bus.lo}, 64'h3FFF_FFFF_0000_0001);

        run_and_check("mul_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        check("mul_min.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        run_and_check("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_and_check("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Leaves hi=0x1111, lo=0x2222 ahead of the divide-by-zero case.
        run_and_check("div_setup", 1'b0, 1'b1, 32'h0444_5111, 32'h0000_2000);
        check("div_setup.const", {bus.hi, bus.lo}, 64'h0000_1111_0000_2222);

        run_and_check("div_zero", 1'b0, 1'b1, 32'd5, 32'd0);
        check("div_zero.const", {bus.hi, bus.lo}, 64'h0000_1111_0000_2222);

        run_and_check("both_ops", 1'b1, 1'b1, 32'd6, 32'd7);
        check("both_ops.const", {bus.hi, bus.lo}, 64'd42);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            bit is_mult;
            ra      = pick_operand();
            rb      = pick_operand();
            is_mult = 1'($urandom_range(0, 1));
            run_and_check($sformatf("rand%0d", i), is_mult, !is_mult, ra, rb);
        end

        run_and_check("pre_rst", 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010);

        // Abort a multiply mid-flight; the divOp pulse in CALC must be ignored.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.divOp = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.divOp = 1'b0;
        check("ignore_div.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_abort.busy", {63'd0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort.hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;

        run_and_check("post_rst", 1'b1, 1'b0, 32'd3, 32'd4);
        check("post_rst.const", {bus.hi, bus.lo}, 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
